// File: rtl/mem_ctrl_pkg.sv
// Shared types, constants and helpers for the byte-serial memory controller.
// Imported by mem_ctrl.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    SRC_IC = 1'b0,
    SRC_LS = 1'b1
  } src_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [31:0] IO_BASE = 32'h0003_0000;
  localparam logic [31:0] IO_SPAN = 32'd8;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int ADDR_W_DEFAULT = 18;

  // Byte count for a load/store size code; the illegal code 11 behaves as a word.
  function automatic logic [2:0] size_to_n(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SIZE_BYTE: n = 3'd1;
      SIZE_HALF: n = 3'd2;
      SIZE_WORD: n = 3'd4;
      default:   n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic is_io(input logic [31:0] addr);
    return (addr >= IO_BASE) && (addr < IO_BASE + IO_SPAN);
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates instruction-fetch and load/store
// requests and sequences them as single-byte accesses on the 8-bit RAM/IO bus.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        ic_rn,
  input  logic [31:0] ic_addr,
  output logic        ic_ready,
  output logic [31:0] ic_value,
  input  logic        ls_rn,
  input  logic        ls_wn,
  input  logic [31:0] ls_addr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_wdata,
  output logic        ls_ready,
  output logic [31:0] ls_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  localparam logic [31:0] ADDR_MASK =
    (ADDR_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << ADDR_W) - 32'd1);

  state_t      state_reg, state_next;
  src_t        src_reg, src_next;
  logic [31:0] base_reg, base_next;
  logic [2:0]  n_reg, n_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [2:0]  issue_idx_reg, issue_idx_next;
  logic [2:0]  cap_idx_reg, cap_idx_next;
  logic        pend1_reg, pend1_next;
  logic        pend2_reg, pend2_next;
  logic        resume_reg, resume_next;
  logic [31:0] asm_reg, asm_next;
  logic [31:0] mem_a_reg, mem_a_next;
  logic [7:0]  mem_dout_reg, mem_dout_next;
  logic        mem_wr_reg, mem_wr_next;
  logic        ic_ready_reg, ic_ready_next;
  logic [31:0] ic_value_reg, ic_value_next;
  logic        ls_ready_reg, ls_ready_next;
  logic [31:0] ls_rdata_reg, ls_rdata_next;

  logic        req_any;
  logic [31:0] req_addr;
  logic [2:0]  req_n;
  src_t        req_src;
  logic [31:0] issue_addr;
  logic [31:0] resume_addr;

  assign issue_addr  = base_reg + {29'd0, issue_idx_reg};
  assign resume_addr = base_reg + {29'd0, cap_idx_reg};

  // Store beats load beats fetch; both LSU requests share the LS address/size.
  always_comb begin
    req_any = ls_wn | ls_rn | ic_rn;
    if (ls_wn || ls_rn) begin
      req_addr = ls_addr;
      req_n    = size_to_n(ls_size);
      req_src  = SRC_LS;
    end else begin
      req_addr = ic_addr;
      req_n    = 3'd4;
      req_src  = SRC_IC;
    end
  end

  always_comb begin
    state_next     = state_reg;
    src_next       = src_reg;
    base_next      = base_reg;
    n_next         = n_reg;
    wdata_next     = wdata_reg;
    issue_idx_next = issue_idx_reg;
    cap_idx_next   = cap_idx_reg;
    pend1_next     = pend1_reg;
    pend2_next     = pend2_reg;
    resume_next    = resume_reg;
    asm_next       = asm_reg;
    mem_a_next     = mem_a_reg;
    mem_dout_next  = mem_dout_reg;
    mem_wr_next    = FALSE;
    ic_ready_next  = FALSE;
    ic_value_next  = ic_value_reg;
    ls_ready_next  = FALSE;
    ls_rdata_next  = ls_rdata_reg;

    if (!rdy) begin
      resume_next = TRUE;
    end else begin
      resume_next = FALSE;
      unique case (state_reg)
        IDLE: begin
          if (req_any) begin
            src_next     = req_src;
            base_next    = req_addr;
            n_next       = req_n;
            wdata_next   = ls_wdata;
            cap_idx_next = 3'd0;
            asm_next     = 32'd0;
            pend2_next   = FALSE;
            mem_a_next   = req_addr & ADDR_MASK;
            // The accept edge already issues byte 0.
            if (ls_wn) begin
              state_next = WRITE;
              pend1_next = FALSE;
              if (is_io(req_addr) && io_buffer_full) begin
                issue_idx_next = 3'd0;
              end else begin
                mem_dout_next  = ls_wdata[7:0];
                mem_wr_next    = TRUE;
                issue_idx_next = 3'd1;
              end
            end else begin
              state_next     = READ;
              pend1_next     = TRUE;
              issue_idx_next = 3'd1;
            end
          end
        end

        READ: begin
          if (resume_reg) begin
            // Data in the RAM pipeline is stale after a pause: re-request from
            // the first uncaptured byte and skip capture this edge.
            mem_a_next     = resume_addr & ADDR_MASK;
            issue_idx_next = cap_idx_reg + 3'd1;
            pend1_next     = TRUE;
            pend2_next     = FALSE;
          end else begin
            pend2_next = pend1_reg;
            if (issue_idx_reg < n_reg) begin
              mem_a_next     = issue_addr & ADDR_MASK;
              issue_idx_next = issue_idx_reg + 3'd1;
              pend1_next     = TRUE;
            end else begin
              pend1_next = FALSE;
            end
            if (pend2_reg) begin
              asm_next[{cap_idx_reg[1:0], 3'b000} +: 8] = mem_din;
              cap_idx_next = cap_idx_reg + 3'd1;
              if (cap_idx_reg == n_reg - 3'd1) begin
                state_next = DONE;
                if (src_reg == SRC_IC) begin
                  ic_value_next = asm_next;
                  ic_ready_next = TRUE;
                end else begin
                  ls_rdata_next = asm_next;
                  ls_ready_next = TRUE;
                end
              end
            end
          end
        end

        WRITE: begin
          if (issue_idx_reg < n_reg) begin
            mem_a_next = issue_addr & ADDR_MASK;
            if (!(is_io(issue_addr) && io_buffer_full)) begin
              mem_dout_next  = byte_sel(wdata_reg, issue_idx_reg[1:0]);
              mem_wr_next    = TRUE;
              issue_idx_next = issue_idx_reg + 3'd1;
            end
          end else begin
            state_next    = DONE;
            ls_ready_next = TRUE;
          end
        end

        DONE: begin
          state_next = IDLE;
        end

        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      src_reg       <= SRC_IC;
      base_reg      <= 32'd0;
      n_reg         <= 3'd0;
      wdata_reg     <= 32'd0;
      issue_idx_reg <= 3'd0;
      cap_idx_reg   <= 3'd0;
      pend1_reg     <= FALSE;
      pend2_reg     <= FALSE;
      resume_reg    <= FALSE;
      asm_reg       <= 32'd0;
      mem_a_reg     <= 32'd0;
      mem_dout_reg  <= 8'd0;
      mem_wr_reg    <= FALSE;
      ic_ready_reg  <= FALSE;
      ic_value_reg  <= 32'd0;
      ls_ready_reg  <= FALSE;
      ls_rdata_reg  <= 32'd0;
    end else begin
      state_reg     <= state_next;
      src_reg       <= src_next;
      base_reg      <= base_next;
      n_reg         <= n_next;
      wdata_reg     <= wdata_next;
      issue_idx_reg <= issue_idx_next;
      cap_idx_reg   <= cap_idx_next;
      pend1_reg     <= pend1_next;
      pend2_reg     <= pend2_next;
      resume_reg    <= resume_next;
      asm_reg       <= asm_next;
      mem_a_reg     <= mem_a_next;
      mem_dout_reg  <= mem_dout_next;
      mem_wr_reg    <= mem_wr_next;
      ic_ready_reg  <= ic_ready_next;
      ic_value_reg  <= ic_value_next;
      ls_ready_reg  <= ls_ready_next;
      ls_rdata_reg  <= ls_rdata_next;
    end
  end

  assign mem_a    = mem_a_reg;
  assign mem_dout = mem_dout_reg;
  assign mem_wr   = mem_wr_reg;
  assign ic_ready = ic_ready_reg;
  assign ic_value = ic_value_reg;
  assign ls_ready = ls_ready_reg;
  assign ls_rdata = ls_rdata_reg;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed testbench for mem_ctrl with a registered-read byte RAM model.
// Each scenario task checks bus activity and ready timing edge by edge.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, ic_rn, ls_rn, ls_wn, io_buffer_full;
  logic [31:0] ic_addr, ls_addr, ls_wdata;
  logic [1:0]  ls_size;
  logic        ic_ready, ls_ready, mem_wr;
  logic [31:0] ic_value, ls_rdata, mem_a;
  logic [7:0]  mem_din, mem_dout;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;

  bit        written [0:262143];
  bit [7:0]  wram    [0:262143];

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .ic_rn(ic_rn), .ic_addr(ic_addr), .ic_ready(ic_ready), .ic_value(ic_value),
    .ls_rn(ls_rn), .ls_wn(ls_wn), .ls_addr(ls_addr), .ls_size(ls_size),
    .ls_wdata(ls_wdata), .ls_ready(ls_ready), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  function automatic logic [7:0] rom_byte(input logic [31:0] a);
    logic [7:0] b;
    case (a)
      32'h0000_1000: b = 8'h13;
      32'h0000_1001: b = 8'h05;
      32'h0000_1002: b = 8'h00;
      32'h0000_1003: b = 8'h00;
      32'h0000_2000: b = 8'h11;
      32'h0000_2001: b = 8'h22;
      32'h0000_2002: b = 8'h33;
      32'h0000_2003: b = 8'h44;
      32'h0000_0000: b = 8'hEF;
      32'h0000_0001: b = 8'hBE;
      32'h0000_0002: b = 8'hAD;
      32'h0000_0003: b = 8'hDE;
      32'h0000_0102: b = 8'h77;
      32'h0003_FFFF: b = 8'h9C;
      default:       b = a[7:0] ^ 8'h5A;
    endcase
    return b;
  endfunction

  // RAM samples the address each edge; data appears one cycle later.
  always @(posedge clk) begin
    mem_din <= written[mem_a[17:0]] ? wram[mem_a[17:0]] : rom_byte(mem_a);
    if (mem_wr) begin
      written[mem_a[17:0]] <= 1'b1;
      wram[mem_a[17:0]]    <= mem_dout;
      wr_count             <= wr_count + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; ic_rn = 1'b0; ls_rn = 1'b0; ls_wn = 1'b0;
    io_buffer_full = 1'b0; ic_addr = 32'd0; ls_addr = 32'd0; ls_size = 2'b00; ls_wdata = 32'd0;
    tick(); tick();
    checks++; if (ic_ready !== 1'b0) begin errors++; $display("FAIL reset ic_ready: got %b expected 0", ic_ready); end
    checks++; if (ls_ready !== 1'b0) begin errors++; $display("FAIL reset ls_ready: got %b expected 0", ls_ready); end
    checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset mem_wr: got %b expected 0", mem_wr); end
    checks++; if (mem_a !== 32'd0) begin errors++; $display("FAIL reset mem_a: got %h expected 0", mem_a); end
    checks++; if (mem_dout !== 8'd0) begin errors++; $display("FAIL reset mem_dout: got %h expected 0", mem_dout); end
    checks++; if (ic_value !== 32'd0) begin errors++; $display("FAIL reset ic_value: got %h expected 0", ic_value); end
    checks++; if (ls_rdata !== 32'd0) begin errors++; $display("FAIL reset ls_rdata: got %h expected 0", ls_rdata); end
    rst = 1'b0;
    tick();
    $display("txn reset outputs cleared");
  endtask

  task automatic test_ic_fetch();
    ic_addr = 32'h0000_1000; ic_rn = 1'b1;
    for (int e = 0; e <= 5; e++) begin
      tick();
      if (e <= 3) begin
        checks++; if (mem_a !== 32'h1000 + e) begin errors++; $display("FAIL ic_fetch mem_a E%0d: got %h expected %h", e, mem_a, 32'h1000 + e); end
      end
      checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL ic_fetch mem_wr E%0d: got %b expected 0", e, mem_wr); end
      checks++; if (ic_ready !== (e == 5)) begin errors++; $display("FAIL ic_fetch ic_ready E%0d: got %b expected %b", e, ic_ready, e == 5); end
    end
    checks++; if (ic_value !== 32'h0000_0513) begin errors++; $display("FAIL ic_fetch ic_value: got %h expected 00000513", ic_value); end
    ic_rn = 1'b0;
    tick();
    checks++; if (ic_ready !== 1'b0) begin errors++; $display("FAIL ic_fetch ready_pulse: got %b expected 0", ic_ready); end
    $display("txn ic_fetch addr=00001000 value=%h", ic_value);
  endtask

  task automatic test_arbitration();
    ls_addr = 32'h0000_2000; ls_size = 2'b10; ls_rn = 1'b1;
    ic_addr = 32'h0000_0000; ic_rn = 1'b1;
    for (int e = 0; e <= 12; e++) begin
      tick();
      checks++; if (ls_ready !== (e == 5)) begin errors++; $display("FAIL arb ls_ready E%0d: got %b expected %b", e, ls_ready, e == 5); end
      checks++; if (ic_ready !== (e == 12)) begin errors++; $display("FAIL arb ic_ready E%0d: got %b expected %b", e, ic_ready, e == 12); end
      if (e == 0) begin
        checks++; if (mem_a !== 32'h2000) begin errors++; $display("FAIL arb ls_first mem_a: got %h expected 00002000", mem_a); end
      end
      if (e == 5) begin
        checks++; if (ls_rdata !== 32'h4433_2211) begin errors++; $display("FAIL arb ls_rdata: got %h expected 44332211", ls_rdata); end
        ls_rn = 1'b0;
      end
      if (e == 7) begin
        checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL arb ic_accept mem_a E7: got %h expected 00000000", mem_a); end
      end
      if (e == 12) begin
        checks++; if (ic_value !== 32'hDEAD_BEEF) begin errors++; $display("FAIL arb ic_value: got %h expected deadbeef", ic_value); end
        ic_rn = 1'b0;
      end
    end
    tick();
    $display("txn arbitration ls=%h ic=%h", ls_rdata, ic_value);
  endtask

  task automatic test_store_half();
    logic [31:0] exp_a [0:1];
    logic [7:0]  exp_d [0:1];
    exp_a[0] = 32'h100; exp_a[1] = 32'h101;
    exp_d[0] = 8'hEF;   exp_d[1] = 8'hBE;
    ls_addr = 32'h0000_0100; ls_size = 2'b01; ls_wdata = 32'h1234_BEEF;
    ls_wn = 1'b1; ls_rn = 1'b1;
    for (int e = 0; e <= 2; e++) begin
      tick();
      checks++; if (mem_wr !== (e < 2)) begin errors++; $display("FAIL store mem_wr E%0d: got %b expected %b", e, mem_wr, e < 2); end
      checks++; if (ls_ready !== (e == 2)) begin errors++; $display("FAIL store ls_ready E%0d: got %b expected %b", e, ls_ready, e == 2); end
      if (e < 2) begin
        checks++; if (mem_a !== exp_a[e]) begin errors++; $display("FAIL store mem_a E%0d: got %h expected %h", e, mem_a, exp_a[e]); end
        checks++; if (mem_dout !== exp_d[e]) begin errors++; $display("FAIL store mem_dout E%0d: got %h expected %h", e, mem_dout, exp_d[e]); end
      end
    end
    ls_wn = 1'b0; ls_rn = 1'b0;
    tick();
    $display("txn store_half addr=00000100 data=beef");
  endtask

  task automatic test_load_unaligned();
    ls_addr = 32'h0000_0101; ls_size = 2'b01; ls_rn = 1'b1;
    for (int e = 0; e <= 3; e++) begin
      tick();
      if (e <= 1) begin
        checks++; if (mem_a !== 32'h101 + e) begin errors++; $display("FAIL load_half mem_a E%0d: got %h expected %h", e, mem_a, 32'h101 + e); end
      end
      checks++; if (ls_ready !== (e == 3)) begin errors++; $display("FAIL load_half ls_ready E%0d: got %b expected %b", e, ls_ready, e == 3); end
    end
    checks++; if (ls_rdata !== 32'h0000_77BE) begin errors++; $display("FAIL load_half ls_rdata: got %h expected 000077be", ls_rdata); end
    ls_rn = 1'b0;
    tick();
    $display("txn load_half addr=00000101 data=%h", ls_rdata);
  endtask

  task automatic test_wrap();
    ls_addr = 32'hFFFF_FFFF; ls_size = 2'b10; ls_rn = 1'b1;
    for (int e = 0; e <= 5; e++) begin
      tick();
      if (e == 0) begin
        checks++; if (mem_a !== 32'h0003_FFFF) begin errors++; $display("FAIL wrap mem_a E0: got %h expected 0003ffff", mem_a); end
      end
      if (e == 1) begin
        checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL wrap mem_a E1: got %h expected 00000000", mem_a); end
      end
      checks++; if (ls_ready !== (e == 5)) begin errors++; $display("FAIL wrap ls_ready E%0d: got %b expected %b", e, ls_ready, e == 5); end
    end
    checks++; if (ls_rdata !== 32'hADBE_EF9C) begin errors++; $display("FAIL wrap ls_rdata: got %h expected adbeef9c", ls_rdata); end
    ls_rn = 1'b0;
    tick();
    $display("txn load_wrap addr=ffffffff data=%h", ls_rdata);
  endtask

  task automatic test_io_stall();
    int wr_before;
    wr_before = wr_count;
    io_buffer_full = 1'b1;
    ls_addr = 32'h0003_0000; ls_size = 2'b00; ls_wdata = 32'h0000_0041; ls_wn = 1'b1;
    for (int e = 0; e <= 4; e++) begin
      tick();
      checks++; if (mem_wr !== (e == 3)) begin errors++; $display("FAIL io_stall mem_wr E%0d: got %b expected %b", e, mem_wr, e == 3); end
      checks++; if (ls_ready !== (e == 4)) begin errors++; $display("FAIL io_stall ls_ready E%0d: got %b expected %b", e, ls_ready, e == 4); end
      if (e == 3) begin
        checks++; if (mem_a !== 32'h0003_0000) begin errors++; $display("FAIL io_stall mem_a: got %h expected 00030000", mem_a); end
        checks++; if (mem_dout !== 8'h41) begin errors++; $display("FAIL io_stall mem_dout: got %h expected 41", mem_dout); end
      end
      if (e == 2) io_buffer_full = 1'b0;
    end
    ls_wn = 1'b0;
    tick();
    checks++; if (wr_count - wr_before !== 1) begin errors++; $display("FAIL io_stall write_count: got %0d expected 1", wr_count - wr_before); end
    $display("txn io_store addr=00030000 data=41");
  endtask

  task automatic test_rst_abort();
    ic_addr = 32'h0000_2000; ic_rn = 1'b1;
    tick(); tick();
    rst = 1'b1; ic_rn = 1'b0;
    tick();
    checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL rst_abort mem_wr: got %b expected 0", mem_wr); end
    checks++; if (mem_a !== 32'd0) begin errors++; $display("FAIL rst_abort mem_a: got %h expected 0", mem_a); end
    checks++; if (ic_value !== 32'd0) begin errors++; $display("FAIL rst_abort ic_value: got %h expected 0", ic_value); end
    rst = 1'b0;
    for (int e = 0; e < 4; e++) begin
      tick();
      checks++; if (ic_ready !== 1'b0) begin errors++; $display("FAIL rst_abort no_ready %0d: got %b expected 0", e, ic_ready); end
    end
    ic_addr = 32'h0000_1000; ic_rn = 1'b1;
    for (int e = 0; e <= 5; e++) begin
      tick();
      checks++; if (ic_ready !== (e == 5)) begin errors++; $display("FAIL rst_refetch ic_ready E%0d: got %b expected %b", e, ic_ready, e == 5); end
    end
    checks++; if (ic_value !== 32'h0000_0513) begin errors++; $display("FAIL rst_refetch ic_value: got %h expected 00000513", ic_value); end
    ic_rn = 1'b0;
    tick();
    $display("txn rst_abort then fetch value=%h", ic_value);
  endtask

  task automatic test_rdy_pause();
    ic_addr = 32'h0000_2000; ic_rn = 1'b1;
    for (int e = 0; e <= 10; e++) begin
      tick();
      checks++; if (ic_ready !== (e == 10)) begin errors++; $display("FAIL pause ic_ready E%0d: got %b expected %b", e, ic_ready, e == 10); end
      checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL pause mem_wr E%0d: got %b expected 0", e, mem_wr); end
      if (e >= 3 && e <= 5) begin
        checks++; if (mem_a !== 32'h2002) begin errors++; $display("FAIL pause mem_a held E%0d: got %h expected 00002002", e, mem_a); end
      end
      if (e == 6) begin
        checks++; if (mem_a !== 32'h2001) begin errors++; $display("FAIL pause rewind mem_a: got %h expected 00002001", mem_a); end
      end
      if (e == 2) rdy = 1'b0;
      if (e == 5) rdy = 1'b1;
    end
    checks++; if (ic_value !== 32'h4433_2211) begin errors++; $display("FAIL pause ic_value: got %h expected 44332211", ic_value); end
    ic_rn = 1'b0;
    tick();
    $display("txn pause_fetch addr=00002000 value=%h", ic_value);
  endtask

  initial begin
    test_reset();
    test_ic_fetch();
    test_arbitration();
    test_store_half();
    test_load_unaligned();
    test_wrap();
    test_io_stall();
    test_rst_abort();
    test_rdy_pause();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller: the responder end of the instruction-cache fetch port, plus the load/store port, in front of the 8-bit unified RAM/IO bus. It accepts word-fetch requests from the instruction cache and 1/2/4-byte load/store requests from the load/store unit. It sequences the required byte accesses on the RAM bus and returns one single-cycle ready pulse per request. It sits between the cache/LSU and the top-level RAM and IO pins.

## Interface
- ADDR_W, 18: RAM address bits actually driven; upper bits of mem_a are zero.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  pause when low (see Operation)
- ic_rn  in  1  fetch request, held high with stable ic_addr until ic_ready
- ic_addr  in  32  fetch address, word-aligned
- ic_ready  out  1  one-cycle pulse, ic_value valid in same cycle
- ic_value  out  32  fetched word, little-endian
- ls_rn  in  1  load request, held until ls_ready
- ls_wn  in  1  store request, held until ls_ready; wins if ls_rn also high
- ls_addr  in  32  byte address, any alignment
- ls_size  in  2  00=1 byte, 01=2 bytes, 10=4 bytes; 11 illegal (treated as 4)
- ls_wdata  in  32  store data, low bytes used
- ls_ready  out  1  one-cycle completion pulse
- ls_rdata  out  32  load data, zero-extended
- mem_din  in  8  RAM read byte, valid one cycle after address registered
- mem_dout  out  8  write byte
- mem_a  out  32  byte address
- mem_wr  out  1  write strobe
- io_buffer_full  in  1  IO write back-pressure

## Operation
- States: IDLE, READ, WRITE, DONE. Reset values: state IDLE; every output 0.
- IDLE: samples requests at each edge with rdy high. Priority is ls_wn > ls_rn > ic_rn. Latches addr, n (1/2/4 bytes), wdata and the source (IC/LS). issue_idx=0, cap_idx=0.
- READ: at edge E_k (k=0..n-1) registers mem_a=base+k, mem_wr=0. At edge E_(k+2) captures mem_din into byte k of an assembly register. After the capture of byte n-1, enters DONE and registers the result into ic_value or ls_rdata together with the matching ready=1.
- WRITE: at edge E_k registers mem_a=base+k, mem_dout=byte k of wdata, mem_wr=1. After byte n-1, next edge sets mem_wr=0 and ls_ready=1 and enters DONE.
- IO stall: address in 0x30000..0x30007, WRITE, io_buffer_full high → mem_wr=0 and issue_idx does not advance. The byte is reissued once the signal drops.
- DONE: ready high for exactly this cycle. Next edge → IDLE, ready=0, and no request is sampled on that edge. ic_value and ls_rdata hold their last value.
- rdy low: all state frozen and mem_wr forced 0. In READ, on the first edge with rdy high again, issue_idx rewinds to cap_idx. In-flight bytes are re-requested, never captured stale.
- rst mid-transaction: abort, mem_wr=0 at that edge, no ready pulse, IDLE.
- Address arithmetic: base+k is 32-bit wrap-around. mem_a[31:ADDR_W] is forced 0.

## Timing
- E0 = edge accepting the request.
- Read of n bytes: ready high in the cycle after E_(n+1). A word takes 6 cycles from accept to ready.
- Write of n bytes: ready high in the cycle after E_n, plus stall cycles.
- Back-to-back: the earliest next accept is 2 edges after the ready pulse starts (DONE→IDLE, then sample).
- A pending IC request behind an LS request is accepted at that earliest slot. No preemption mid-transfer.

## Structure
- Shared constants header gets these constants:
  - state encodings
  - size codes
  - IO_BASE=0x30000
  - True/False
- No sub-module; arbitration, byte sequencing and assembly live in one module.

## Test plan
- IC fetch 0x00001000, RAM bytes 13 05 00 00 → mem_a 0x1000..0x1003 at E0..E3; ic_ready single pulse after E5; ic_value=0x00000513.
- ls_rn (0x2000, size 10) and ic_rn (0x0) raised on the same edge → LS served first; ls_ready after E5; IC accepted at E7; ic_ready after E12.
- Store halfword 0xBEEF to 0x100 → mem_wr at 0x100=EF and 0x101=BE on E0 and E1; ls_ready after E2.
- Store byte 0x41 to 0x30000 with io_buffer_full high for 3 cycles → mem_wr 0 for 3 cycles, then exactly one write; ls_ready the following cycle.
- rst asserted after 2 bytes of a word fetch → no ic_ready, mem_wr 0, IDLE. A re-issued fetch returns the correct word with normal latency.
- rdy low for 3 cycles after E2 of a word fetch → ic_value still exact; no byte captured while paused.
